// File: rtl/imem_fetch_arbiter.sv
// imem_fetch_arbiter
// Instruction-fetch stage that shares a single instruction-memory port with a
// program loader. In normal operation it fetches one word per cycle into the
// IF/ID register. The hazard unit can freeze it, a taken branch can redirect
// it, and the loader can take the port over to write program words.
//
// Ports
//   clk, reset       single clock, synchronous active-high reset
//   stall_i          hold the fetch stage
//   redirect_i       taken branch/jump: flush and restart at redirect_pc_i
//   redirect_pc_i    byte target of the redirect (low two bits dropped)
//   load_req_i       loader requests the memory port
//   load_addr_i      loader byte write address
//   load_data_i      loader write word
//   load_gnt_o       loader owns the memory port this cycle
//   mem_addr_o       byte address to instruction memory
//   mem_we_o         memory write enable
//   mem_wdata_o      memory write word
//   mem_rdata_i      combinational read data from memory
//   pc_o             PC of instr_o
//   instr_o          fetched instruction (IF/ID register)
//   instr_valid_o    instr_o holds a real instruction
//   misalign_o       one-cycle pulse for a non-word-aligned redirect target

module imem_fetch_arbiter #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [WIDTH-1:0] redirect_pc_i,
  input  logic             load_req_i,
  input  logic [WIDTH-1:0] load_addr_i,
  input  logic [WIDTH-1:0] load_data_i,
  output logic             load_gnt_o,
  output logic [WIDTH-1:0] mem_addr_o,
  output logic             mem_we_o,
  output logic [WIDTH-1:0] mem_wdata_o,
  input  logic [WIDTH-1:0] mem_rdata_i,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] instr_o,
  output logic             instr_valid_o,
  output logic             misalign_o
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    STALL = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] fetch_pc;
  logic [WIDTH-1:0] aligned_target;
  logic             target_misaligned;

  assign aligned_target    = {redirect_pc_i[WIDTH-1:2], 2'b00};
  assign target_misaligned = |redirect_pc_i[1:0];

  // Control FSM and all registered outputs. STALL with stall_i low behaves
  // exactly like FETCH: the held fetch_pc is already on the memory port, so
  // its word is captured on that same edge. Priority outside LOAD is
  // redirect, then load request, then stall. A redirect coinciding with a
  // load request still updates fetch_pc before the loader takes over, so
  // fetching resumes at the branch target once the load finishes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= FETCH;
      fetch_pc      <= RESET_PC;
      pc_o          <= '0;
      instr_o       <= '0;
      instr_valid_o <= 1'b0;
      misalign_o    <= 1'b0;
      load_gnt_o    <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          misalign_o <= 1'b0;
          if (!load_req_i) begin
            state      <= FETCH;
            load_gnt_o <= 1'b0;
          end
        end
        default: begin
          misalign_o <= redirect_i && target_misaligned;
          if (redirect_i) begin
            fetch_pc      <= aligned_target;
            instr_valid_o <= 1'b0;
            if (load_req_i) begin
              state      <= LOAD;
              load_gnt_o <= 1'b1;
            end else begin
              state <= FETCH;
            end
          end else if (load_req_i) begin
            state         <= LOAD;
            load_gnt_o    <= 1'b1;
            instr_valid_o <= 1'b0;
          end else if (stall_i) begin
            state <= STALL;
          end else begin
            state         <= FETCH;
            instr_o       <= mem_rdata_i;
            pc_o          <= fetch_pc;
            instr_valid_o <= 1'b1;
            fetch_pc      <= fetch_pc + WIDTH'(4);
          end
        end
      endcase
    end
  end

  // Memory port steering. The loader drives the port only while granted.
  // Otherwise the port always presents fetch_pc as a read, so a stalled
  // fetch keeps its address stable.
  always_comb begin
    mem_addr_o  = fetch_pc;
    mem_we_o    = 1'b0;
    mem_wdata_o = '0;
    if (state == LOAD) begin
      mem_addr_o  = load_addr_i;
      mem_we_o    = load_req_i;
      mem_wdata_o = load_data_i;
    end
  end

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// tb_imem_fetch_arbiter
// Self-checking bench for imem_fetch_arbiter. A 64-word memory array serves
// the DUT's port, and writes from the DUT are applied to that array. A
// reference model tracks only what is visible at the interface: the next
// fetch address, the IF/ID contents, and whether the loader currently owns
// the port. The directed scenarios come first, followed by a randomized run.

module tb_imem_fetch_arbiter;

  localparam int          W        = 32;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        load_req_i;
  logic [31:0] load_addr_i;
  logic [31:0] load_data_i;
  logic        load_gnt_o;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
  logic        instr_valid_o;
  logic        misalign_o;

  logic [31:0] mem_words [64];

  logic [31:0] m_fetch   = '0;
  logic [31:0] m_pc      = '0;
  logic [31:0] m_instr   = '0;
  logic        m_valid   = 1'b0;
  logic        m_mis     = 1'b0;
  logic        m_loading = 1'b0;
  logic        m_known   = 1'b0;

  int passed = 0;
  int total  = 0;

  logic [31:0] wd [3];

  always #5 clk = ~clk;

  // Reads are combinational. Upper address bits are folded into the data so
  // that far-away addresses (for example, near the wrap point) return
  // distinguishable words.
  assign mem_rdata_i = mem_words[mem_addr_o[7:2]] ^ {mem_addr_o[31:8], 8'h00};

  imem_fetch_arbiter #(.WIDTH(W), .RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .load_req_i    (load_req_i),
    .load_addr_i   (load_addr_i),
    .load_data_i   (load_data_i),
    .load_gnt_o    (load_gnt_o),
    .mem_addr_o    (mem_addr_o),
    .mem_we_o      (mem_we_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_rdata_i   (mem_rdata_i),
    .pc_o          (pc_o),
    .instr_o       (instr_o),
    .instr_valid_o (instr_valid_o),
    .misalign_o    (misalign_o)
  );

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem_words[a[7:2]] ^ {a[31:8], 8'h00};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Interface-level rules: reset wins over everything. While the loader owns
  // the port, only load_req_i dropping matters. Otherwise the priority is
  // redirect, then load request, then stall, and else a word is fetched.
  task automatic model_update();
    if (reset) begin
      m_fetch   = RESET_PC;
      m_pc      = '0;
      m_instr   = '0;
      m_valid   = 1'b0;
      m_mis     = 1'b0;
      m_loading = 1'b0;
      m_known   = 1'b1;
    end else if (m_loading) begin
      m_mis = 1'b0;
      if (!load_req_i) m_loading = 1'b0;
    end else begin
      m_mis = redirect_i && (redirect_pc_i[1:0] != 2'b00);
      if (redirect_i) begin
        m_fetch   = redirect_pc_i & ~32'h3;
        m_valid   = 1'b0;
        m_loading = load_req_i;
      end else if (load_req_i) begin
        m_valid   = 1'b0;
        m_loading = 1'b1;
      end else if (!stall_i) begin
        m_instr = rd(m_fetch);
        m_pc    = m_fetch;
        m_valid = 1'b1;
        m_fetch = m_fetch + 32'd4;
      end
    end
  endtask

  // One clock cycle. The memory port is checked just after the inputs
  // settle, the model advances at the edge, any DUT write lands in memory
  // after the edge, and the registered outputs are checked one time unit
  // after the edge.
  task automatic cycle();
    logic        w_we;
    logic [31:0] w_addr;
    logic [31:0] w_data;
    #1;
    if (m_known) begin
      chk("load_gnt_pre", load_gnt_o, m_loading);
      chk("mem_addr", mem_addr_o, m_loading ? load_addr_i : m_fetch);
      chk("mem_we", mem_we_o, m_loading & load_req_i);
      chk("mem_wdata", mem_wdata_o, m_loading ? load_data_i : 32'h0);
    end
    w_we   = mem_we_o;
    w_addr = mem_addr_o;
    w_data = mem_wdata_o;
    @(posedge clk);
    model_update();
    #1;
    if (w_we === 1'b1) mem_words[w_addr[7:2]] = w_data;
    if (m_known) begin
      chk("pc", pc_o, m_pc);
      chk("instr", instr_o, m_instr);
      chk("instr_valid", instr_valid_o, m_valid);
      chk("misalign", misalign_o, m_mis);
      chk("load_gnt", load_gnt_o, m_loading);
    end
  endtask

  task automatic applyStimulus_idle();
    reset         = 1'b0;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    load_req_i    = 1'b0;
    load_addr_i   = '0;
    load_data_i   = '0;
  endtask

  initial begin
    int n;
    int load_left;
    for (int i = 0; i < 64; i++) mem_words[i] = $urandom;
    for (int i = 0; i < 3; i++) wd[i] = $urandom;

    applyStimulus_idle();
    reset = 1'b1;
    cycle();
    cycle();
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_valid", instr_valid_o, 1'b0);
    chk("rst_gnt", load_gnt_o, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("seq_pc", pc_o, 32'(i * 4));
      chk("seq_valid", instr_valid_o, 1'b1);
    end

    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_pc", pc_o, 32'h8);
      chk("stall_instr", instr_o, mem_words[2]);
    end
    stall_i = 1'b0;
    cycle();
    chk("after_stall_pc", pc_o, 32'hC);

    stall_i = 1'b1;
    cycle();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h40;
    cycle();
    chk("redir_flush", instr_valid_o, 1'b0);
    redirect_i = 1'b0;
    stall_i    = 1'b0;
    cycle();
    chk("redir_pc", pc_o, 32'h40);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h42;
    cycle();
    chk("mis_pulse", misalign_o, 1'b1);
    redirect_i = 1'b0;
    cycle();
    chk("mis_pc", pc_o, 32'h40);
    chk("mis_clear", misalign_o, 1'b0);

    redirect_i    = 1'b1;
    redirect_pc_i = 32'h10;
    cycle();
    redirect_i = 1'b0;
    load_req_i = 1'b1;
    n = 0;
    for (int k = 0; k < 10 && n < 3; k++) begin
      logic granted;
      load_addr_i = 32'(n * 4);
      load_data_i = wd[n];
      granted     = m_loading;
      cycle();
      if (granted) begin
        chk("load_valid", instr_valid_o, 1'b0);
        n++;
      end
    end
    chk("load_writes", 32'(n), 32'd3);
    load_req_i = 1'b0;
    cycle();
    chk("load_release", load_gnt_o, 1'b0);
    cycle();
    chk("load_resume_pc", pc_o, 32'h10);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0;
    cycle();
    redirect_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("loaded_word", instr_o, wd[i]);
    end

    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    cycle();
    redirect_i = 1'b0;
    cycle();
    chk("wrap_top", pc_o, 32'hFFFF_FFFC);
    cycle();
    chk("wrap_zero", pc_o, 32'h0);

    load_req_i = 1'b1;
    cycle();
    cycle();
    chk("mid_load_gnt", load_gnt_o, 1'b1);
    reset = 1'b1;
    cycle();
    chk("rst_load_gnt", load_gnt_o, 1'b0);
    chk("rst_load_pc", pc_o, 32'h0);
    reset      = 1'b0;
    load_req_i = 1'b0;
    cycle();
    chk("first_fetch_pc", pc_o, RESET_PC);

    load_left = 0;
    for (int c = 0; c < 400; c++) begin
      reset         = ($urandom_range(0, 63) == 0);
      redirect_i    = ($urandom_range(0, 7) == 0);
      redirect_pc_i = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                  : 32'($urandom_range(0, 255));
      stall_i       = ($urandom_range(0, 3) == 0);
      if (load_left == 0 && $urandom_range(0, 9) == 0) load_left = $urandom_range(1, 5);
      load_req_i    = (load_left != 0);
      if (load_left > 0) load_left--;
      load_addr_i   = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      load_data_i   = $urandom;
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/imem_fetch_arbiter.md
IMEM_FETCH_ARBITER -- requirements
Module: imem_fetch_arbiter

Interface
REQ-001 Parameter WIDTH, default 32: width of PC, addresses, instruction and load data.
REQ-002 Parameter RESET_PC, default 0: byte address loaded into PC on reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall_i  input  1  hazard-unit hold request for the fetch stage.
REQ-006 redirect_i  input  1  branch/jump taken; flush and load redirect_pc_i.
REQ-007 redirect_pc_i  input  WIDTH  byte target of redirect.
REQ-008 load_req_i  input  1  program loader requests the memory port.
REQ-009 load_addr_i  input  WIDTH  loader byte write address.
REQ-010 load_data_i  input  WIDTH  loader write word.
REQ-011 load_gnt_o  output  1  loader owns the port this cycle.
REQ-012 mem_addr_o  output  WIDTH  byte address to instruction memory.
REQ-013 mem_we_o  output  1  memory write enable.
REQ-014 mem_wdata_o  output  WIDTH  memory write word.
REQ-015 mem_rdata_i  input  WIDTH  combinational read data from memory.
REQ-016 pc_o  output  WIDTH  PC of instr_o.
REQ-017 instr_o  output  WIDTH  fetched instruction (IF/ID register).
REQ-018 instr_valid_o  output  1  instr_o holds a real instruction.
REQ-019 misalign_o  output  1  one-cycle pulse: redirect target not word-aligned.

Function
REQ-020 The block SHALL implement FSM states FETCH, STALL, LOAD; internal register fetch_pc holds the next byte address to fetch.
REQ-021 FETCH: mem_addr_o = fetch_pc, mem_we_o = 0; at edge instr_o <= mem_rdata_i, pc_o <= fetch_pc, instr_valid_o <= 1, fetch_pc <= fetch_pc + 4 (one-cycle latency).
REQ-022 PC increment SHALL be modulo 2^WIDTH; fetch_pc = 2^WIDTH-4 SHALL advance to 0.
REQ-023 stall_i = 1 in FETCH (no redirect, no load) SHALL enter STALL with fetch_pc, pc_o, instr_o, instr_valid_o unchanged.
REQ-024 STALL SHALL hold all outputs; stall_i = 0 returns to FETCH, fetching the held fetch_pc that cycle.
REQ-025 redirect_i = 1 in FETCH or STALL SHALL, at that edge, set fetch_pc <= {redirect_pc_i[WIDTH-1:2], 2'b00}, instr_valid_o <= 0, next state FETCH; redirect overrides stall_i.
REQ-026 If redirect_pc_i[1:0] != 0 while redirect_i = 1, misalign_o SHALL be 1 for the following cycle only.
REQ-027 load_req_i = 1 with redirect_i = 0 SHALL enter LOAD at next edge; instr_valid_o <= 0, fetch_pc held.
REQ-028 Simultaneous redirect_i and load_req_i: redirect applied to fetch_pc, then LOAD entered at the same edge.
REQ-029 LOAD: load_gnt_o = 1, mem_addr_o = load_addr_i, mem_we_o = load_req_i, mem_wdata_o = load_data_i; one word per cycle; stall_i and redirect_i ignored.
REQ-030 load_req_i = 0 in LOAD SHALL return to FETCH at next edge, resuming at held fetch_pc; no write that cycle.
REQ-031 load_gnt_o and mem_we_o SHALL be 0 outside LOAD; mem_wdata_o = 0 outside LOAD.

Reset
REQ-032 reset = 1 at an edge SHALL set state FETCH, fetch_pc = RESET_PC, pc_o = 0, instr_o = 0, instr_valid_o = 0, misalign_o = 0, load_gnt_o = 0, overriding all inputs, including mid-LOAD or mid-STALL.
REQ-033 First fetch SHALL occur in the first cycle after reset deasserts, at RESET_PC.

Verification
REQ-034 Reset, then 4 free cycles with memory at 0,4,8,12 -> pc_o 0,4,8,12 on consecutive cycles, instr_valid_o = 1 from cycle 1.
REQ-035 stall_i high 3 cycles at pc_o = 8 -> pc_o/instr_o frozen 3 cycles, then pc_o = 12 next.
REQ-036 redirect_i with target 0x40 while stalled -> instr_valid_o = 0 one cycle, then pc_o = 0x40; target 0x42 -> misalign_o pulse, pc_o = 0x40.
REQ-037 load_req_i 3 cycles writing 0x0,0x4,0x8 mid-fetch at fetch_pc 0x10 -> 3 writes with load_gnt_o = 1, instr_valid_o = 0, fetch resumes at 0x10.
REQ-038 fetch_pc = 0xFFFFFFFC -> next pc_o = 0; reset asserted during LOAD -> load_gnt_o = 0, pc_o = 0 next cycle.
